// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns the async FIFO pop/empty read port into a bubble-free
// valid/ready stream. Optional transfer counter enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int WIDTH     = 16,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_rdata,
    output logic             o_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] o_xfer_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    generate
        if (BUF_DEPTH < 2 || BUF_DEPTH > 4 || CNT_W < 1 || WIDTH < 1) begin : g_bad_param
            $error("fifo_rd_stream: illegal parameter set");
        end
    endgenerate

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic             infl_reg;
    logic [OCC_W:0]   level;
    logic             deq;
    logic [WIDTH-1:0] entry [BUF_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reserve a slot for the word still in flight so a pop can never overflow.
    always_comb begin
        level   = {1'b0, occ_reg} + (OCC_W + 1)'(infl_reg);
        o_pop   = !i_empty && (level < (OCC_W + 1)'(BUF_DEPTH));
        o_valid = (occ_reg != '0);
        deq     = o_valid && i_ready;
    end

    always_comb begin
        occ_next  = occ_reg + OCC_W'(infl_reg) - OCC_W'(deq);
        head_next = deq ? ptr_inc(head_reg) : head_reg;
        tail_next = infl_reg ? ptr_inc(tail_reg) : tail_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ_reg  <= '0;
            infl_reg <= 1'b0;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            occ_reg  <= occ_next;
            infl_reg <= o_pop;
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    entry_reg <= '0;
                end else if (infl_reg && (tail_reg == PTR_W'(gi))) begin
                    entry_reg <= i_rdata;
                end
            end

            assign entry[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        o_data = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (head_reg == PTR_W'(i)) begin
                o_data = entry[i];
            end
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_W-1:0] xfer_cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xfer_cnt_reg <= '0;
        end else if (deq) begin
            xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(1);
        end
    end

    assign o_xfer_cnt = xfer_cnt_reg;
`endif

    a_level_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        level <= (OCC_W + 1)'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO read port model plus
// a scoreboard of expected stream beats.
module tb_fifo_rd_stream;

    localparam int WIDTH     = 16;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 4;

    logic             clk;
    logic             rst_n;
    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic             pop;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_W-1:0] xfer_cnt;
`endif

    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] exp_q  [$];
    int               pop_cnt;
    int               nchecks;
    int               nerrs;
    bit               hold;
    logic [WIDTH-1:0] hold_data;

    fifo_rd_stream #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_empty    (empty),
        .i_rdata    (rdata),
        .o_pop      (pop),
        .o_valid    (valid),
        .o_data     (data),
        .i_ready    (ready)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .o_xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchecks++;
        if (obs !== expv) begin
            nerrs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // FIFO read port: data registered the cycle after an accepted pop, held otherwise.
    always @(posedge clk) begin
        if (rst_n && pop && fifo_q.size() > 0) begin
            logic [WIDTH-1:0] w;
            w = fifo_q.pop_front();
            rdata <= w;
            pop_cnt++;
        end
        empty <= (fifo_q.size() == 0);
    end

    // Stream monitor: scoreboard, stability under backpressure, no pop while empty.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_data", 32'(data), 32'(hold_data));
            end
            if (empty) check("pop_while_empty", 32'(pop), 32'd0);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(data), 32'hFFFF_FFFF);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    $display("beat data=0x%04h expected=0x%04h", data, e);
                    check("beat", 32'(data), 32'(e));
                end
            end
            hold      = valid && !ready;
            hold_data = data;
        end
    end

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_pop", 32'(pop), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pop_cnt = 0;
    endtask

    task automatic run_drain(input string tag, input int limit, input bit toggle);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < limit) begin
            @(posedge clk);
            #1;
            if (toggle) ready = ~ready;
            @(negedge clk);
            #1;
            c++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int first_pop, first_valid, last_valid, nvalid;
        nchecks = 0;
        nerrs   = 0;
        pop_cnt = 0;
        hold    = 1'b0;
        rst_n   = 1'b0;
        ready   = 1'b0;
        empty   = 1'b1;
        rdata   = '0;

        // Pre-filled FIFO, consumer always ready.
        reset_dut();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) push(WIDTH'(i));
        ready       = 1'b1;
        first_pop   = -1;
        first_valid = -1;
        last_valid  = -1;
        nvalid      = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (pop && first_pop < 0) first_pop = c;
            if (valid) begin
                if (first_valid < 0) first_valid = c;
                last_valid = c;
                nvalid++;
            end
        end
        check("t1_first_pop", 32'(first_pop), 32'd0);
        check("t1_first_valid", 32'(first_valid), 32'd2);
        check("t1_last_valid", 32'(last_valid), 32'd6);
        check("t1_nvalid", 32'(nvalid), 32'd5);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Same fill, consumer stalled: prefetch stops at BUF_DEPTH.
        reset_dut();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) push(WIDTH'(i));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t2_pops", 32'(pop_cnt), 32'd3);
        check("t2_pop_low", 32'(pop), 32'd0);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_data", 32'(data), 32'h0001);
        @(posedge clk);
        #1;
        ready = 1'b1;
        run_drain("t2_drain", 20, 1'b0);

        // Single word.
        reset_dut();
        @(posedge clk);
        #1;
        push(16'hA5A5);
        ready  = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("t3_pops", 32'(pop_cnt), 32'd1);
        check("t3_nvalid", 32'(nvalid), 32'd1);
        check("t3_idle", 32'(valid), 32'd0);

        // 20-word stream with ready toggling 1,0,1,0.
        reset_dut();
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) push(WIDTH'(16'h1000 + i));
        ready = 1'b0;
        run_drain("t4_drain", 100, 1'b1);
        check("t4_pops", 32'(pop_cnt), 32'd20);

        // Reset the cycle after a pop with two words buffered.
        reset_dut();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) push(WIDTH'(16'h0200 + i));
        ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_data", 32'(data), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        empty = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pop_cnt = 0;
        @(posedge clk);
        #1;
        push(16'h00FF);
        ready = 1'b1;
        run_drain("t5_drain", 20, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5_pops", 32'(pop_cnt), 32'd1);
        check("t5_idle", 32'(valid), 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
        // 18 beats through a 4-bit counter wraps to 2.
        reset_dut();
        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) push(WIDTH'(16'h3000 + i));
        ready = 1'b1;
        run_drain("t6_drain", 60, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_xfer_cnt", 32'(xfer_cnt), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side adapter that sits directly downstream of the async FIFO, in its read clock domain.
- The FIFO read port has three properties this block must handle:
  - pop/empty interface;
  - read data registered one cycle after an accepted pop;
  - read data held until the next pop.
- This block converts that port into a valid/ready stream with no bubbles.
- It prefetches words into a small internal skid buffer.
- There is no combinational path from i_ready to o_pop.

Parameters:
- WIDTH, 16, data width; must match the FIFO WIDTH.
- BUF_DEPTH, 3, skid buffer entries. Legal range 2..4. Full throughput is required only for BUF_DEPTH ≥ 3.
- CNT_W, 16, transfer counter width; used only with the optional feature.

Ports:
- i_clk  input  1  FIFO read clock.
- i_rst_n  input  1  asynchronous active-low reset; same net as the FIFO read reset.
- i_empty  input  1  FIFO empty flag.
- i_rdata  input  WIDTH  FIFO read data; valid the cycle after o_pop=1 with i_empty=0.
- o_pop  output  1  pop request to the FIFO.
- o_valid  output  1  stream data valid.
- o_data  output  WIDTH  stream data (buffer head).
- i_ready  input  1  stream consumer ready.
- o_xfer_cnt  output  CNT_W  accepted beat count. Present only with FIFO_RD_STREAM_CNT_EN.

Behaviour:
- Reset (asynchronous, active low):
  - o_valid=0, o_data=0, o_pop=0.
  - Occupancy occ=0, in-flight flag infl=0.
  - Buffer contents = 0; o_xfer_cnt = 0.
- o_pop is combinational: o_pop = !i_empty && (occ + infl) < BUF_DEPTH.
  - It depends only on registered state and i_empty, never on i_ready.
- infl (next) = o_pop. o_pop is asserted only when i_empty=0, so every pop is accepted by the FIFO.
- Capture: when infl=1, i_rdata is written to the buffer tail that cycle. i_rdata is ignored when infl=0.
- Dequeue (deq) = o_valid && i_ready. The head is removed on the rising edge.
- Occupancy: occ_next = occ + infl − deq.
  - Simultaneous enqueue and dequeue leaves occ unchanged.
  - Enqueue into an empty buffer is visible on o_valid the next cycle. Total latency from pop to o_valid is 2 cycles.
- Buffer is a circular array with head/tail pointers of width clog2(BUF_DEPTH). Pointers wrap explicitly at BUF_DEPTH−1, so non-power-of-2 depths are legal.
- Invariant: occ + infl ≤ BUF_DEPTH at all times. Overflow is impossible by construction; a verification assertion must check it.
- Output rules:
  - o_valid = (occ != 0). o_data = buffer[head].
  - While o_valid=1 and i_ready=0, o_valid and o_data stay stable.
  - o_valid never deasserts without a handshake.
- Throughput:
  - BUF_DEPTH ≥ 3 with i_ready held high and the FIFO non-empty gives one beat per cycle after the initial 2-cycle fill.
  - BUF_DEPTH=2 gives at most 2 beats per 3 cycles.
- i_empty toggling:
  - i_empty may rise at any time, including the cycle after a pop. The in-flight word is still captured.
  - No speculative pops are issued.
- Backpressure: with i_ready=0, popping stops once occ + infl = BUF_DEPTH. The FIFO retains the remainder.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - Because the FIFO read side shares i_rst_n, its read pointer is reset as well. No stale word may appear after reset release.
- No state machine beyond the occ/infl counters. Stream order equals FIFO order.

Optional Feature:
FIFO_RD_STREAM_CNT_EN
- Defined:
  - o_xfer_cnt port exists.
  - A CNT_W-bit register increments on every deq and wraps modulo 2^CNT_W.
  - Reset value 0.
- Undefined: the port and the register are absent. All other behaviour is identical.

Test Plan:
- FIFO pre-filled with 0x0001..0x0005, i_ready=1, BUF_DEPTH=3:
  - first o_pop at cycle 0, first o_valid at cycle 2;
  - beats 0x0001..0x0005 on consecutive cycles 2..6;
  - o_pop never asserted while i_empty=1.
- Same fill, i_ready=0 throughout:
  - exactly 3 pops issued, then o_pop stays 0;
  - o_valid=1 and o_data=0x0001 held stable;
  - raising i_ready then drains 0x0001..0x0005 in order.
- Single word 0xA5A5 written, i_ready=1: one pop; o_valid high for exactly 1 cycle with 0xA5A5; occ returns to 0.
- i_ready toggling 1,0,1,0 over a continuous 20-word stream:
  - all 20 words delivered in order with no duplicates or drops;
  - assertion occ + infl ≤ BUF_DEPTH holds.
- i_rst_n asserted the cycle after a pop with 2 words buffered:
  - o_valid=0 and o_data=0 immediately;
  - after release with the FIFO refilled with 0x00FF, the only beat delivered is 0x00FF.
- With FIFO_RD_STREAM_CNT_EN and CNT_W=4, 18 beats transferred: o_xfer_cnt=2 (wrapped).
